// File: rtl/rvseed_test_monitor_pkg.sv
// Shared constants for the rvseed end-of-test monitor: 3-bit state encodings,
// default protocol register indices and the write-back index match helper.
package rvseed_test_monitor_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_PASS    = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;
  localparam logic [2:0] ST_TIMEOUT = 3'd5;

  localparam int unsigned RV_DONE_REG    = 26;
  localparam int unsigned RV_PASS_REG    = 27;
  localparam int unsigned RV_TESTNUM_REG = 3;

  // x0 is hardwired to zero in the core, so a write to index 0 never matches.
  function automatic logic reg_hit(input logic wen, input logic [31:0] addr,
                                   input logic [31:0] idx);
    return wen && (addr != '0) && (addr == idx);
  endfunction

endpackage

// File: rtl/rvseed_mon_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
module rvseed_mon_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rvseed_test_monitor.sv
// End-of-test monitor snooping rvseed write-back; decides PASS/FAIL/TIMEOUT.
// Define RVSEED_MON_RETIRE_CNT_EN to add the retire_cnt port and counter.
module rvseed_test_monitor
  import rvseed_test_monitor_pkg::*;
#(
  parameter int unsigned CPU_WIDTH   = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned DONE_REG    = RV_DONE_REG,
  parameter int unsigned PASS_REG    = RV_PASS_REG,
  parameter int unsigned TESTNUM_REG = RV_TESTNUM_REG,
  parameter int unsigned SETTLE_CYC  = 1,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rf_wen,
  input  logic [REG_ADDR_W-1:0] rf_waddr,
  input  logic [CPU_WIDTH-1:0]  rf_wdata,
  input  logic                  inst_retire,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [CPU_WIDTH-1:0]  fail_testnum,
  output logic [CNT_W-1:0]      cycle_cnt
`ifdef RVSEED_MON_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]      retire_cnt
`endif
);

  logic [2:0]           state_q, state_d;
  logic [CPU_WIDTH-1:0] pass_sh_q, pass_sh_d;
  logic [CPU_WIDTH-1:0] tn_sh_q, tn_sh_d;
  logic [CPU_WIDTH-1:0] ftn_q, ftn_d;
  logic [31:0]          settle_q, settle_d;
  logic                 done_q, pass_q, fail_q, tmo_q;

  logic                 wr_done, wr_pass, wr_tn, active, tmo_hit;
  logic [CPU_WIDTH-1:0] pass_now, tn_now;

  assign wr_done = reg_hit(rf_wen, 32'(rf_waddr), 32'(DONE_REG))
                   && (rf_wdata == CPU_WIDTH'(1));
  assign wr_pass = reg_hit(rf_wen, 32'(rf_waddr), 32'(PASS_REG));
  assign wr_tn   = reg_hit(rf_wen, 32'(rf_waddr), 32'(TESTNUM_REG));

  // Decision sees a protocol write landing in the same cycle.
  assign pass_now = wr_pass ? rf_wdata : pass_sh_q;
  assign tn_now   = wr_tn   ? rf_wdata : tn_sh_q;

  assign active  = (state_q == ST_RUN) || (state_q == ST_SETTLE);
  assign tmo_hit = (cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    pass_sh_d = pass_sh_q;
    tn_sh_d   = tn_sh_q;
    ftn_d     = ftn_q;
    settle_d  = settle_q;
    if (start) begin
      state_d   = ST_RUN;
      pass_sh_d = '0;
      tn_sh_d   = '0;
      ftn_d     = '0;
      settle_d  = '0;
    end else if (active) begin
      if (wr_pass) pass_sh_d = rf_wdata;
      if (wr_tn)   tn_sh_d   = rf_wdata;
      // Done detect and settle decision outrank the cycle budget.
      if (state_q == ST_RUN) begin
        if (wr_done) begin
          state_d  = ST_SETTLE;
          settle_d = 32'(SETTLE_CYC);
        end else if (tmo_hit) begin
          state_d = ST_TIMEOUT;
        end
      end else if (settle_q == '0) begin
        if (pass_now == CPU_WIDTH'(1)) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_FAIL;
          ftn_d   = tn_now;
        end
      end else begin
        settle_d = settle_q - 1'b1;
        if (tmo_hit) state_d = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pass_sh_q <= '0;
      tn_sh_q   <= '0;
      ftn_q     <= '0;
      settle_q  <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pass_sh_q <= pass_sh_d;
      tn_sh_q   <= tn_sh_d;
      ftn_q     <= ftn_d;
      settle_q  <= settle_d;
      done_q    <= (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
      pass_q    <= (state_d == ST_PASS);
      fail_q    <= (state_d == ST_FAIL);
      tmo_q     <= (state_d == ST_TIMEOUT);
    end
  end

  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = tmo_q;
  assign fail_testnum = ftn_q;

  rvseed_mon_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (start),
    .en_i  (active),
    .cnt_o (cycle_cnt)
  );

`ifdef RVSEED_MON_RETIRE_CNT_EN
  rvseed_mon_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (start),
    .en_i  (active && inst_retire),
    .cnt_o (retire_cnt)
  );
`else
  logic unused_retire;
  assign unused_retire = inst_retire;
`endif

endmodule

// File: tb/tb_rvseed_test_monitor.sv
// Bench for rvseed_test_monitor: three differently parametrised instances share
// one stimulus stream; outcomes are predicted from the protocol rules per run.
module tb_rvseed_test_monitor;

  localparam int L = 45;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rf_wen = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic        inst_retire = 1'b0;

  logic        done_w[3], pass_w[3], fail_w[3], tmo_w[3];
  logic [31:0] ftn_w[3], cyc_w[3];
`ifdef RVSEED_MON_RETIRE_CNT_EN
  logic [31:0] ret_w[3];
`endif

  int checks = 0;
  int failures = 0;

  // Per-instance parameters: A, B, C.
  int pd[3]  = '{26, 26, 0};
  int pp[3]  = '{27, 27, 27};
  int ptn[3] = '{3, 3, 3};
  int ps[3]  = '{1, 0, 2};
  int pt[3]  = '{40, 20, 30};

  // Schedule indexed by edge number after (and including) the start edge.
  bit          w_en[L+1];
  int          w_addr[L+1];
  logic [31:0] w_data[L+1];
  bit          ret[L+1];

  int          term[3];
  bit          e_pass[3], e_fail[3], e_tmo[3];
  logic [31:0] e_ftn[3];
  int          e_ret[3];

  always #5 clk = ~clk;

  rvseed_test_monitor #(.SETTLE_CYC(1), .TIMEOUT_CYC(40)) u_a (
    .clk(clk), .rst(rst), .start(start), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .inst_retire(inst_retire), .done(done_w[0]), .pass(pass_w[0]),
    .fail(fail_w[0]), .timeout(tmo_w[0]), .fail_testnum(ftn_w[0]), .cycle_cnt(cyc_w[0])
`ifdef RVSEED_MON_RETIRE_CNT_EN
    , .retire_cnt(ret_w[0])
`endif
  );

  rvseed_test_monitor #(.SETTLE_CYC(0), .TIMEOUT_CYC(20)) u_b (
    .clk(clk), .rst(rst), .start(start), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .inst_retire(inst_retire), .done(done_w[1]), .pass(pass_w[1]),
    .fail(fail_w[1]), .timeout(tmo_w[1]), .fail_testnum(ftn_w[1]), .cycle_cnt(cyc_w[1])
`ifdef RVSEED_MON_RETIRE_CNT_EN
    , .retire_cnt(ret_w[1])
`endif
  );

  rvseed_test_monitor #(.DONE_REG(0), .SETTLE_CYC(2), .TIMEOUT_CYC(30)) u_c (
    .clk(clk), .rst(rst), .start(start), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .inst_retire(inst_retire), .done(done_w[2]), .pass(pass_w[2]),
    .fail(fail_w[2]), .timeout(tmo_w[2]), .fail_testnum(ftn_w[2]), .cycle_cnt(cyc_w[2])
`ifdef RVSEED_MON_RETIRE_CNT_EN
    , .retire_cnt(ret_w[2])
`endif
  );

  task automatic chk(input string tag, input int inst, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int n = 0; n <= L; n++) begin
      w_en[n] = 1'b0; w_addr[n] = 0; w_data[n] = '0; ret[n] = 1'b0;
    end
  endtask

  task automatic add_wr(input int n, input int a, input logic [31:0] d);
    w_en[n] = 1'b1; w_addr[n] = a; w_data[n] = d;
  endtask

  task automatic drive_edge(input int n);
    rf_wen      = w_en[n];
    rf_waddr    = 5'(w_addr[n]);
    rf_wdata    = w_data[n];
    inst_retire = ret[n];
  endtask

  // Outcome from the protocol rules: first valid done write k (edge numbers
  // after start), decision at k+SETTLE+1 unless the budget edge falls in between.
  task automatic compute_expected();
    for (int i = 0; i < 3; i++) begin
      int k, e;
      logic [31:0] pv, tv;
      k = -1;
      for (int n = 1; n <= L; n++)
        if (k < 0 && w_en[n] && pd[i] != 0 && w_addr[n] == pd[i] && w_data[n] == 32'd1)
          k = n;
      e_pass[i] = 1'b0; e_fail[i] = 1'b0; e_tmo[i] = 1'b0; e_ftn[i] = '0;
      e = k + ps[i] + 1;
      if (k < 0 || k > pt[i] || (k < pt[i] && e > pt[i])) begin
        term[i] = pt[i];
        e_tmo[i] = 1'b1;
      end else begin
        term[i] = e;
        pv = '0; tv = '0;
        for (int n = 1; n <= e; n++) begin
          if (w_en[n] && pp[i] != 0 && w_addr[n] == pp[i]) pv = w_data[n];
          if (w_en[n] && ptn[i] != 0 && w_addr[n] == ptn[i]) tv = w_data[n];
        end
        e_pass[i] = (pv == 32'd1);
        e_fail[i] = !e_pass[i];
        e_ftn[i]  = e_fail[i] ? tv : '0;
      end
      e_ret[i] = 0;
      for (int n = 1; n <= term[i]; n++) e_ret[i] += int'(ret[n]);
    end
  endtask

  task automatic run_scenario();
    compute_expected();
    start = 1'b1;
    drive_edge(0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n <= L; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
        chk("done", i, 64'(done_w[i]), 64'(n >= term[i]));
        chk("cycle_cnt", i, 64'(cyc_w[i]), 64'((n < term[i]) ? n : term[i]));
      end
      if (n < L) drive_edge(n + 1);
      else begin
        rf_wen = 1'b0; inst_retire = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk("pass", i, 64'(pass_w[i]), 64'(e_pass[i]));
      chk("fail", i, 64'(fail_w[i]), 64'(e_fail[i]));
      chk("timeout", i, 64'(tmo_w[i]), 64'(e_tmo[i]));
      chk("fail_testnum", i, 64'(ftn_w[i]), 64'(e_ftn[i]));
`ifdef RVSEED_MON_RETIRE_CNT_EN
      chk("retire_cnt", i, 64'(ret_w[i]), 64'(e_ret[i]));
`endif
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_done"}, i, 64'(done_w[i]), 64'(0));
      chk({tag, "_pass"}, i, 64'(pass_w[i]), 64'(0));
      chk({tag, "_fail"}, i, 64'(fail_w[i]), 64'(0));
      chk({tag, "_timeout"}, i, 64'(tmo_w[i]), 64'(0));
      chk({tag, "_ftn"}, i, 64'(ftn_w[i]), 64'(0));
      chk({tag, "_cycle_cnt"}, i, 64'(cyc_w[i]), 64'(0));
`ifdef RVSEED_MON_RETIRE_CNT_EN
      chk({tag, "_retire_cnt"}, i, 64'(ret_w[i]), 64'(0));
`endif
    end
  endtask

  initial begin
    int kd, sel;
    logic [31:0] d;
    int addrs[5];
    clear_sched();

    // Reset state, then IDLE must hold with nothing counting.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 chk_all_zero("idle");

    // Pass then done; also an x0 write that instance C must ignore; 7 retires.
    clear_sched();
    add_wr(3, 27, 32'd1); add_wr(5, 0, 32'd1); add_wr(10, 26, 32'd1);
    for (int n = 1; n <= 7; n++) ret[n] = 1'b1;
    run_scenario();

    // Fail with test number capture.
    clear_sched();
    add_wr(2, 3, 32'd5); add_wr(4, 27, 32'd0); add_wr(6, 26, 32'd1);
    run_scenario();

    // Pass flag written one and two cycles after done.
    clear_sched();
    add_wr(8, 26, 32'd1); add_wr(9, 27, 32'd1);
    run_scenario();
    clear_sched();
    add_wr(8, 26, 32'd1); add_wr(10, 27, 32'd1);
    run_scenario();

    // Non-1 done value ignored -> timeout everywhere.
    clear_sched();
    add_wr(7, 26, 32'd2);
    run_scenario();

    // Done around the budget edge of instance B.
    clear_sched();
    add_wr(19, 26, 32'd1);
    run_scenario();
    clear_sched();
    add_wr(20, 26, 32'd1); add_wr(21, 27, 32'd1);
    run_scenario();

    // Done write in the start cycle is discarded.
    clear_sched();
    add_wr(0, 26, 32'd1);
    run_scenario();

    clear_sched();
    add_wr(1, 0, 32'd1); add_wr(2, 3, 32'd9); add_wr(3, 26, 32'd1);
    run_scenario();

    // Reset while instance A is settling.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rf_wen = 1'b1; rf_waddr = 5'd26; rf_wdata = 32'd1;
    @(posedge clk); #1;
    rf_wen = 1'b0;
    chk("settling_done", 0, 64'(done_w[0]), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("mid_settle_rst");
    repeat (2) @(posedge clk);
    #1 chk_all_zero("post_rst_idle");

    // start and rst together: reset wins, monitor stays idle.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("start_with_rst");

    // Randomized runs, each restarting from the previous terminal state.
    addrs = '{26, 27, 3, 0, 0};
    for (int s = 0; s < 40; s++) begin
      clear_sched();
      if ($urandom_range(4) != 0) begin
        kd = int'($urandom_range(28, 1));
        add_wr(kd, 26, 32'd1);
      end
      for (int n = 0; n <= 35; n++) begin
        ret[n] = $urandom_range(1) == 1;
        if (!w_en[n] && $urandom_range(2) == 0) begin
          sel = int'($urandom_range(4));
          addrs[4] = int'($urandom_range(31));
          case ($urandom_range(3))
            0:       d = 32'd1;
            1:       d = 32'd0;
            2:       d = 32'd2;
            default: d = $urandom;
          endcase
          add_wr(n, addrs[sel], d);
        end
      end
      run_scenario();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
